// File: rtl/exe_stage.sv
// Execute stage: ALU / effective-address unit with registered outputs for the memory stage.
// Define EXE_DIV_EN to include the iterative 32-step unsigned divider (DIVU/REMU) and its FSM.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_stall,
  input  logic        ex_bubble,
  input  logic [5:0]  optype,
  input  logic [4:0]  regaddr3,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] imm,
  input  logic [4:0]  shamt,
  output logic [5:0]  to_optype,
  output logic [4:0]  to_regaddr3,
  output logic [31:0] alu_ans,
  output logic [31:0] swdata,
  output logic        ex_busy
);

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_NOR  = 6'h05;
  localparam logic [5:0] OP_SLT  = 6'h06;
  localparam logic [5:0] OP_SLTU = 6'h07;
  localparam logic [5:0] OP_SLL  = 6'h08;
  localparam logic [5:0] OP_SRL  = 6'h09;
  localparam logic [5:0] OP_SRA  = 6'h0A;
  localparam logic [5:0] OP_LUI  = 6'h0B;
  localparam logic [5:0] OP_ADDI = 6'h10;
  localparam logic [5:0] OP_ORI  = 6'h11;
  localparam logic [5:0] OP_MUL  = 6'h12;
  localparam logic [5:0] OP_LW   = 6'h13;
  localparam logic [5:0] OP_SW   = 6'h14;
  localparam logic [5:0] OP_NOP  = 6'h3F;

  logic [31:0] alu;
  logic [31:0] result;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
  always_comb begin
    alu = '0;
    case (optype)
      OP_ADD:         alu = rs_val + rt_val;
      OP_SUB:         alu = rs_val - rt_val;
      OP_AND:         alu = rs_val & rt_val;
      OP_OR:          alu = rs_val | rt_val;
      OP_XOR:         alu = rs_val ^ rt_val;
      OP_NOR:         alu = ~(rs_val | rt_val);
      OP_SLT:         alu = {31'b0, $signed(rs_val) < $signed(rt_val)};
      OP_SLTU:        alu = {31'b0, rs_val < rt_val};
      OP_SLL:         alu = rt_val << shamt;
      OP_SRL:         alu = rt_val >> shamt;
      OP_SRA:         alu = $unsigned($signed(rt_val) >>> shamt);
      OP_LUI:         alu = {imm[15:0], 16'b0};
      OP_ADDI:        alu = rs_val + imm;
      OP_ORI:         alu = rs_val | imm;
      OP_MUL:         alu = rs_val * rt_val;
      OP_LW, OP_SW:   alu = rs_val + imm;
      default:        alu = '0;
    endcase
  end

`ifdef EXE_DIV_EN
  localparam logic [5:0] OP_DIVU = 6'h19;
  localparam logic [5:0] OP_REMU = 6'h1A;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] divisor;
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic        is_div;

  assign is_div    = (optype == OP_DIVU) || (optype == OP_REMU);
  assign rem_shift = {rem, quo[31]};
  assign trial     = rem_shift - {1'b0, divisor};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
    end else if (!ex_stall) begin
      case (state)
        ST_IDLE: if (is_div) begin
          state <= ST_DIV;
          count <= 5'd31;
        end
        ST_DIV: begin
          if (count == 5'd0) state <= ST_DONE;
          else               count <= count - 5'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; the FSM guarantees they are loaded before being read.
  always_ff @(posedge clk) begin
    if (!ex_stall) begin
      if (state == ST_IDLE && is_div) begin
        quo     <= rs_val;
        divisor <= rt_val;
        rem     <= '0;
      end else if (state == ST_DIV) begin
        // Restoring step; a zero divisor always "fits", giving all-ones quotient and rem = rs.
        if (!trial[32]) begin
          rem <= trial[31:0];
          quo <= {quo[30:0], 1'b1};
        end else begin
          rem <= rem_shift[31:0];
          quo <= {quo[30:0], 1'b0};
        end
      end
    end
  end

  assign ex_busy = (state == ST_DIV) || (state == ST_IDLE && is_div);
  assign result  = (state == ST_DONE) ? ((optype == OP_REMU) ? rem : quo) : alu;
`else
  assign ex_busy = 1'b0;
  assign result  = alu;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      to_optype   <= OP_NOP;
      to_regaddr3 <= '0;
      alu_ans     <= '0;
      swdata      <= '0;
    end else if (ex_bubble) begin
      to_optype <= OP_NOP;
    end else if (!ex_stall) begin
      if (ex_busy) begin
        to_optype <= OP_NOP;
      end else begin
        to_optype   <= optype;
        to_regaddr3 <= regaddr3;
        alu_ans     <= result;
        swdata      <= rt_val;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: reset, ALU and memory ops, stall/bubble, and (with EXE_DIV_EN) the divider.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, ex_stall, ex_bubble;
  logic [5:0]  optype;
  logic [4:0]  regaddr3;
  logic [31:0] rs_val, rt_val, imm;
  logic [4:0]  shamt;
  logic [5:0]  to_optype;
  logic [4:0]  to_regaddr3;
  logic [31:0] alu_ans, swdata;
  logic        ex_busy;

  int checks = 0;
  int errors = 0;

  exe_stage dut (
    .clk(clk), .rst(rst), .ex_stall(ex_stall), .ex_bubble(ex_bubble),
    .optype(optype), .regaddr3(regaddr3), .rs_val(rs_val), .rt_val(rt_val),
    .imm(imm), .shamt(shamt), .to_optype(to_optype), .to_regaddr3(to_regaddr3),
    .alu_ans(alu_ans), .swdata(swdata), .ex_busy(ex_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] i, input logic [4:0] sh, input logic [4:0] rd);
    optype = o; rs_val = a; rt_val = b; imm = i; shamt = sh; regaddr3 = rd;
  endtask

`ifdef EXE_DIV_EN
  // Runs one divide from issue through DONE and the result edge; stalls for stall_len
  // cycles once stall_at busy cycles have elapsed. Returns the number of busy cycles.
  task automatic run_div(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int stall_at, input int stall_len, output int busy_n);
    logic nop_ok;
    nop_ok = 1'b1;
    busy_n = 0;
    op(o, a, b, 32'h0, 5'd0, 5'd9);
    check("busy_at_issue", {31'b0, ex_busy}, 32'd1);
    while (ex_busy && busy_n < 200) begin
      ex_stall = (busy_n >= stall_at) && (busy_n < stall_at + stall_len);
      tick();
      busy_n++;
      if (to_optype !== 6'h3F) nop_ok = 1'b0;
    end
    ex_stall = 1'b0;
    check("div_interim_nop", {31'b0, nop_ok}, 32'd1);
    tick();
    check("div_optype", {26'b0, to_optype}, {26'b0, o});
    check("div_regaddr3", {27'b0, to_regaddr3}, 32'd9);
  endtask
`endif

  initial begin
    int n;
    rst = 1'b1; ex_stall = 1'b0; ex_bubble = 1'b0;
    op(6'h3F, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    tick(); tick();
    check("rst_optype", {26'b0, to_optype}, 32'h3F);
    check("rst_alu", alu_ans, 32'h0);
    check("rst_swdata", swdata, 32'h0);
    check("rst_regaddr3", {27'b0, to_regaddr3}, 32'h0);
    check("rst_busy", {31'b0, ex_busy}, 32'h0);
    rst = 1'b0;

    op(6'h00, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'd0, 5'd5); tick();
    check("add_ans", alu_ans, 32'h8000_0000);
    check("add_optype", {26'b0, to_optype}, 32'h00);
    check("add_rd", {27'b0, to_regaddr3}, 32'd5);
    op(6'h06, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0, 5'd6); tick();
    check("slt", alu_ans, 32'h1);
    op(6'h07, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0, 5'd6); tick();
    check("sltu", alu_ans, 32'h0);
    op(6'h0A, 32'h0, 32'h8000_0000, 32'h0, 5'd4, 5'd7); tick();
    check("sra", alu_ans, 32'hF800_0000);
    op(6'h09, 32'h0, 32'h8000_0000, 32'h0, 5'd4, 5'd7); tick();
    check("srl", alu_ans, 32'h0800_0000);
    op(6'h01, 32'h5, 32'h7, 32'h0, 5'd0, 5'd1); tick();
    check("sub", alu_ans, 32'hFFFF_FFFE);
    op(6'h05, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0, 5'd0, 5'd1); tick();
    check("nor", alu_ans, 32'h0F0F_F0F0);
    op(6'h0B, 32'h0, 32'h0, 32'h0000_1234, 5'd0, 5'd2); tick();
    check("lui", alu_ans, 32'h1234_0000);
    op(6'h12, 32'h0001_0000, 32'h0001_0001, 32'h0, 5'd0, 5'd3); tick();
    check("mul", alu_ans, 32'h0001_0000);
    op(6'h10, 32'h10, 32'h0, 32'hFFFF_FFFC, 5'd0, 5'd3); tick();
    check("addi", alu_ans, 32'h0000_000C);

    op(6'h14, 32'h70, 32'h1234, 32'h0C, 5'd0, 5'd0); tick();
    check("sw_addr", alu_ans, 32'h7C);
    check("sw_data", swdata, 32'h1234);
    check("sw_optype", {26'b0, to_optype}, 32'h14);
    op(6'h13, 32'h74, 32'h0, 32'h0, 5'd0, 5'd8); tick();
    check("lw_addr", alu_ans, 32'h74);
    check("lw_optype", {26'b0, to_optype}, 32'h13);
    op(6'h20, 32'h1, 32'h2, 32'h3, 5'd1, 5'd4); tick();
    check("undef_ans", alu_ans, 32'h0);
    check("undef_optype", {26'b0, to_optype}, 32'h20);

    // Stall holds, bubble wins over stall, bubble alone keeps the data fields.
    op(6'h00, 32'h1, 32'h1, 32'h0, 5'd0, 5'd4);
    ex_stall = 1'b1; tick();
    check("stall_optype", {26'b0, to_optype}, 32'h20);
    check("stall_ans", alu_ans, 32'h0);
    ex_bubble = 1'b1; tick();
    check("bub_stall_optype", {26'b0, to_optype}, 32'h3F);
    ex_stall = 1'b0; ex_bubble = 1'b0;
    op(6'h00, 32'h2, 32'h2, 32'h0, 5'd0, 5'd4); tick();
    check("add_after_bubble", alu_ans, 32'h4);
    ex_bubble = 1'b1; tick();
    check("bubble_optype", {26'b0, to_optype}, 32'h3F);
    check("bubble_hold_ans", alu_ans, 32'h4);
    ex_bubble = 1'b0;

`ifdef EXE_DIV_EN
    run_div(6'h19, 32'd100, 32'd7, -1, 0, n);
    check("divu_busy_cycles", n, 32'd33);
    check("divu_100_7", alu_ans, 32'd14);
    run_div(6'h1A, 32'd100, 32'd7, -1, 0, n);
    check("remu_100_7", alu_ans, 32'd2);
    run_div(6'h19, 32'd5, 32'd0, -1, 0, n);
    check("divu_by_zero", alu_ans, 32'hFFFF_FFFF);
    run_div(6'h1A, 32'd5, 32'd0, -1, 0, n);
    check("remu_by_zero", alu_ans, 32'd5);
    run_div(6'h19, 32'd1000, 32'd10, 10, 5, n);
    check("divu_stall_cycles", n, 32'd38);
    check("divu_stall_ans", alu_ans, 32'd100);

    // Reset in the middle of a divide.
    op(6'h19, 32'd100, 32'd7, 32'h0, 5'd0, 5'd9);
    for (int i = 0; i < 10; i++) tick();
    check("mid_div_busy", {31'b0, ex_busy}, 32'd1);
    rst = 1'b1;
    op(6'h3F, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    tick();
    check("rst_mid_busy", {31'b0, ex_busy}, 32'd0);
    check("rst_mid_optype", {26'b0, to_optype}, 32'h3F);
    rst = 1'b0;
    op(6'h00, 32'd2, 32'd3, 32'h0, 5'd0, 5'd1); tick();
    check("add_after_rst", alu_ans, 32'd5);
    check("add_after_rst_op", {26'b0, to_optype}, 32'h00);
`else
    n = 0;
    op(6'h19, 32'd100, 32'd7, 32'h0, 5'd0, 5'd9);
    check("nodiv_busy", {31'b0, ex_busy}, 32'd0);
    tick();
    check("nodiv_ans", alu_ans, 32'h0);
    check("nodiv_optype", {26'b0, to_optype}, 32'h19);
    op(6'h1A, 32'd100, 32'd7, 32'h0, 5'd0, 5'd9); tick();
    check("nodiv_rem_optype", {26'b0, to_optype}, 32'h1A);
    op(6'h00, 32'd2, 32'd3, 32'h0, 5'd0, 5'd1); tick();
    check("add_after_div", alu_ans, 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the multi-cycle/pipelined MIPS core; sits directly upstream of the data-memory stage. Consumes a decoded op (optype, operands, immediate, destination register), computes the ALU result / effective address and store data, and registers them for the memory stage. Integer unsigned divide/remainder runs on an iterative 32-step FSM that stalls the front end via `ex_busy`. Bubble and stall controls match the downstream stage's semantics.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_stall` in 1: hold output registers and divider FSM.
- `ex_bubble` in 1: inject bubble (`to_optype`=0x3F); priority over `ex_stall`.
- `optype` in 6: decoded op; 0x3F = nop/bubble.
- `regaddr3` in 5: destination register.
- `rs_val` in 32: operand A.
- `rt_val` in 32: operand B / store data.
- `imm` in 32: sign- or zero-extended immediate, prepared by decode.
- `shamt` in 5: shift amount.
- `to_optype` out 6: registered optype for the memory stage.
- `to_regaddr3` out 5: registered destination.
- `alu_ans` out 32: registered result or effective address.
- `swdata` out 32: registered store data (`rt_val`).
- `ex_busy` out 1: combinational; upstream must hold all inputs stable while high.

## Operation
- Op encodings:
  - 0x00 ADD rs+rt; 0x01 SUB rs−rt; 0x02 AND; 0x03 OR; 0x04 XOR; 0x05 NOR.
  - 0x06 SLT (signed, result 0/1); 0x07 SLTU.
  - 0x08 SLL rt<<shamt; 0x09 SRL; 0x0A SRA.
  - 0x0B LUI imm<<16; 0x10 ADDI rs+imm; 0x11 ORI rs|imm; 0x12 MUL low 32 bits of rs*rt.
  - 0x13 LW rs+imm; 0x14 SW rs+imm with `swdata`=rt.
  - 0x19 DIVU quotient; 0x1A REMU remainder.
  - Any other code: `alu_ans`=0, optype passed through.
- Arithmetic is modulo 2^32. No overflow traps.
- Divider FSM states:
  - IDLE: on 0x19/0x1A with no stall, latch rs and rt, clear the remainder, set count=31, go to DIV.
  - DIV: one restoring step per cycle (shift, subtract, set quotient bit). At count==0 go to DONE; otherwise decrement.
  - DONE: output registers load the quotient or remainder with the op's optype/regaddr3, then return to IDLE.
- `ex_busy` = (state==DIV) | (state==IDLE & optype∈{0x19,0x1A}). It is low in DONE.
- While in DIV, the output register loads a bubble (`to_optype`=0x3F) each non-stalled cycle.
- Divide by zero: quotient 0xFFFF_FFFF, remainder = rs.
- Output register priority, mirroring the downstream stage:
  - `rst` loads the reset values.
  - else `ex_bubble` sets `to_optype`=0x3F; other outputs hold.
  - else `!ex_stall` loads new values.
  - else hold.
- `ex_stall` freezes the FSM and its counter. `ex_bubble` does not affect the FSM.

## Timing
- Reset values: `to_optype`=0x3F, `to_regaddr3`=0, `alu_ans`=0, `swdata`=0, FSM=IDLE, `ex_busy`=0.
- Single-cycle ops: inputs at edge N, outputs valid after edge N+1 (latency 1, throughput 1/cycle).
- DIVU/REMU timing:
  - Issue cycle in IDLE (busy=1), then 32 DIV cycles (busy=1), then DONE (busy=0).
  - Result appears after the edge ending DONE, 34 cycles after issue when unstalled.
  - Upstream advances on the edge ending DONE.
- Reset asserted mid-divide: FSM returns to IDLE at the next edge, the partial result is discarded, and `ex_busy` drops that cycle.
- Back-to-back divides: the second op is seen in IDLE on the cycle after DONE, so there is no overlap.
- Stall and bubble in the same cycle: bubble wins.

## Configuration
- `EXE_DIV_EN` defined: the iterative divider and FSM are present, as described above.
- `EXE_DIV_EN` undefined:
  - 0x19/0x1A complete in one cycle with `alu_ans`=0.
  - `ex_busy` is tied to 0.
  - No FSM or divider registers are synthesized.

## Test plan
- Reset: hold `rst` 2 cycles → `to_optype`=0x3F, `alu_ans`=0, `ex_busy`=0.
- ALU ops:
  - ADD rs=0x7FFF_FFFF, rt=1 → `alu_ans`=0x8000_0000 one cycle later.
  - SLT rs=0xFFFF_FFFF, rt=1 → 1.
  - SLTU on the same operands → 0.
  - SRA rt=0x8000_0000, shamt=4 → 0xF800_0000.
- Memory ops:
  - SW rs=0x70, imm=0x0C, rt=0x1234 → `alu_ans`=0x7C, `swdata`=0x1234, `to_optype`=0x14.
  - LW rs=0x74, imm=0 → `alu_ans`=0x74, `to_optype`=0x13.
- Divider (EXE_DIV_EN):
  - DIVU 100/7 → busy high 33 cycles, then `alu_ans`=14.
  - REMU 100/7 → 2.
  - DIVU x/0 with rs=5 → 0xFFFF_FFFF.
  - Intermediate `to_optype`=0x3F throughout the divide.
- Stall/bubble:
  - `ex_stall` for 5 cycles mid-divide → result delayed exactly 5 cycles.
  - `ex_bubble`+`ex_stall` together → `to_optype`=0x3F.
- Reset mid-divide at cycle 10 → `ex_busy`=0 next cycle; a following ADD 2+3 → 5 with latency 1.
